// File: rtl/fetch_unit_if.sv
// Shared width package plus the two bus bundles of the fetch stage:
// the instruction-memory request bus and the IF/ID decode handshake.
package fetch_pkg;
    localparam int WIDTH = 32;
endpackage

interface imem_if;
    import fetch_pkg::*;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_valid;
    logic [WIDTH-1:0] imem_instr;

    modport master (output imem_req, imem_addr, input imem_valid, imem_instr);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_instr);
endinterface

interface dec_if;
    import fetch_pkg::*;
    logic             if_valid;
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc;
    logic             dec_ready;

    modport master (output if_valid, if_instr, if_pc, input dec_ready);
    modport slave  (input if_valid, if_instr, if_pc, output dec_ready);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word-aligned imem reads, buffers {pc, instr}
// in a small FIFO for decode, and flushes everything on a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_if.master           imem,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    dec_if.master            dec
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fetch_entry_t;

    fetch_entry_t     mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pc;

    logic full;
    logic empty;
    logic req;
    logic push;
    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Request depends only on registered occupancy and redirect, never on dec_ready.
    assign req  = rst_n && !full && !redirect_valid;
    assign push = req && imem.imem_valid;
    assign pop  = !empty && dec.dec_ready && !redirect_valid;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    assign dec.if_valid = !empty;
    assign dec.if_pc    = empty ? '0 : mem[head].pc;
    assign dec.if_instr = empty ? '0 : mem[head].instr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[WIDTH-1:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc   <= pc + WIDTH'(4);
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; count gates every read,
    // so stale entries are never observed and the array maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: pc, instr: imem.imem_instr};
        end
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n) pc[1:0] == 2'b00);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based model of the fetch stream checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    imem_if imem_bus ();
    dec_if  dec_bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: answers after `lat` waiting cycles (0 = combinational ROM).
    int lat = 0;
    int wcnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        wcnt <= 0;
        else if (imem_bus.imem_req && !imem_bus.imem_valid) wcnt <= wcnt + 1;
        else                                               wcnt <= 0;
    end
    always_comb begin
        imem_bus.imem_valid = imem_bus.imem_req && (wcnt >= lat);
        imem_bus.imem_instr = rom(imem_bus.imem_addr);
    end

    // Model: queue of PCs buffered for decode, next PC to fetch, last popped PC.
    logic [31:0] q[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] last_pc;
    bit          have_last = 0;
    bit          e_valid;
    bit          e_req;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
            check("rst_valid", {31'b0, dec_bus.if_valid},  32'h0);
            check("rst_if_pc", dec_bus.if_pc,              32'h0);
            q.delete();
            m_pc      = RESET_PC;
            have_last = 0;
        end else begin
            e_valid = (q.size() != 0);
            e_req   = (q.size() < DEPTH) && !redirect_valid;
            check("m_if_valid", {31'b0, dec_bus.if_valid}, {31'b0, e_valid});
            check("m_if_pc",    dec_bus.if_pc,    e_valid ? q[0] : 32'h0);
            check("m_if_instr", dec_bus.if_instr, e_valid ? rom(q[0]) : 32'h0);
            check("m_req",      {31'b0, imem_bus.imem_req}, {31'b0, e_req});
            check("m_align",    {30'b0, imem_bus.imem_addr[1:0]}, 32'h0);
            if (e_req) check("m_addr", imem_bus.imem_addr, m_pc);
            if (redirect_valid) begin
                q.delete();
                m_pc      = {redirect_pc[31:2], 2'b00};
                have_last = 0;
            end else begin
                if (e_valid && dec_bus.dec_ready) begin
                    if (have_last) check("m_order", dec_bus.if_pc, last_pc + 32'd4);
                    last_pc   = q.pop_front();
                    have_last = 1;
                end
                if (e_req && imem_bus.imem_valid) begin
                    q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_now_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        check("rst_now_valid", {31'b0, dec_bus.if_valid},  32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_bus.dec_ready = 1'b1;

        // Streaming with combinational memory.
        lat = 0;
        apply_reset();
        mid();
        check("t1_addr0",  imem_bus.imem_addr, 32'h0);
        check("t1_req0",   {31'b0, imem_bus.imem_req}, 32'h1);
        check("t1_valid0", {31'b0, dec_bus.if_valid},  32'h0);
        cyc(); mid();
        check("t1_valid1", {31'b0, dec_bus.if_valid}, 32'h1);
        check("t1_pc0",    dec_bus.if_pc,      32'h0);
        check("t1_addr4",  imem_bus.imem_addr, 32'h4);
        cyc(); mid();
        check("t1_pc4", dec_bus.if_pc, 32'h4);
        cyc(); mid();
        check("t1_pc8",    dec_bus.if_pc,    32'h8);
        check("t1_instr8", dec_bus.if_instr, 32'h1B57_9BDF);
        repeat (6) cyc();

        // Decode stalled: FIFO fills with 0 and 4, request held at 8.
        dec_bus.dec_ready = 1'b0;
        apply_reset();
        repeat (5) cyc();
        mid();
        check("t2_valid", {31'b0, dec_bus.if_valid}, 32'h1);
        check("t2_head",  dec_bus.if_pc,      32'h0);
        check("t2_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        check("t2_addr",  imem_bus.imem_addr, 32'h8);
        cyc();
        dec_bus.dec_ready = 1'b1;
        mid();
        check("t2_pop0", dec_bus.if_pc, 32'h0);
        check("t2_req_full", {31'b0, imem_bus.imem_req}, 32'h0);
        cyc(); mid();
        check("t2_pop4",  dec_bus.if_pc, 32'h4);
        check("t2_reissue", {31'b0, imem_bus.imem_req}, 32'h1);
        check("t2_addr8", imem_bus.imem_addr, 32'h8);
        cyc(); mid();
        check("t2_pop8", dec_bus.if_pc, 32'h8);

        // Slow memory: three wait cycles per request.
        lat = 3;
        apply_reset();
        repeat (3) cyc();
        mid();
        check("t3_wait_valid", {31'b0, dec_bus.if_valid}, 32'h0);
        check("t3_wait_addr",  imem_bus.imem_addr, 32'h0);
        cyc(); mid();
        check("t3_first_valid", {31'b0, dec_bus.if_valid}, 32'h1);
        check("t3_first_pc",    dec_bus.if_pc,      32'h0);
        check("t3_next_addr",   imem_bus.imem_addr, 32'h4);
        for (int i = 0; i < 24; i++) begin
            cyc();
            dec_bus.dec_ready = (i % 5) != 2;
        end
        dec_bus.dec_ready = 1'b1;

        // Redirect to an unaligned target while the FIFO is full.
        lat = 0;
        dec_bus.dec_ready = 1'b0;
        apply_reset();
        cyc(); cyc();
        redirect_valid    = 1'b1;
        redirect_pc       = 32'h0000_0103;
        dec_bus.dec_ready = 1'b1;
        mid();
        check("t4_req_redir", {31'b0, imem_bus.imem_req}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        mid();
        check("t4_flushed", {31'b0, dec_bus.if_valid}, 32'h0);
        check("t4_addr",    imem_bus.imem_addr, 32'h100);
        cyc(); mid();
        check("t4_pc", dec_bus.if_pc, 32'h100);

        // PC wrap at the top of the address space.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        mid();
        check("t5_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
        cyc(); mid();
        check("t5_pc_top",   dec_bus.if_pc,      32'hFFFF_FFFC);
        check("t5_addr_wrap", imem_bus.imem_addr, 32'h0);
        cyc(); mid();
        check("t5_pc_wrap", dec_bus.if_pc, 32'h0);

        // Back-to-back redirects: the second target wins.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cyc();
        redirect_pc    = 32'h0000_0300;
        cyc();
        redirect_valid = 1'b0;
        mid();
        check("t6_addr",  imem_bus.imem_addr, 32'h300);
        check("t6_valid", {31'b0, dec_bus.if_valid}, 32'h0);
        cyc(); mid();
        check("t6_pc", dec_bus.if_pc, 32'h300);

        // Reset asserted mid-stream with the FIFO full.
        cyc();
        dec_bus.dec_ready = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        check("t7_valid_now", {31'b0, dec_bus.if_valid},  32'h0);
        check("t7_req_now",   {31'b0, imem_bus.imem_req}, 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        mid();
        check("t7_addr", imem_bus.imem_addr, RESET_PC);
        check("t7_req",  {31'b0, imem_bus.imem_req}, 32'h1);
        cyc(); mid();
        check("t7_head", dec_bus.if_pc, RESET_PC);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-stage initiator: owns the PC and issues word-aligned read requests on the instruction-memory req/valid interface.
- Captures each returned instruction, with its PC, into a small FIFO, and presents them in order to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing buffered and in-flight work.
- Sits between the PC logic and the IF/ID boundary of the pipelined core.

Parameters:
- WIDTH, 32, address/instruction width (package value)
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, fetch FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  WIDTH  byte address of request (bits[1:0] always 0)
- imem_valid  input  1  memory response valid, sampled only while imem_req=1
- imem_instr  input  WIDTH  instruction returned with imem_valid
- redirect_valid  input  1  redirect PC this cycle
- redirect_pc  input  WIDTH  redirect target
- if_valid  output  1  instruction available to decode
- if_instr  output  WIDTH  head instruction
- if_pc  output  WIDTH  PC of head instruction
- dec_ready  input  1  decode accepts head this cycle

Behaviour:
- Interface decision: one clock (clk); reset asynchronous, active-low (rst_n). All state clears immediately on rst_n=0.
- Reset state:
  - pc=RESET_PC; FIFO empty; if_valid=0; imem_req=0 while rst_n=0.
  - if_instr/if_pc=0 when empty.
- Request rule:
  - imem_req = !full && !redirect_valid; imem_addr = pc.
  - No combinational path from dec_ready to imem_req.
- Completion:
  - A request completes in any cycle with imem_req=1 && imem_valid=1. Memory may return valid in the request cycle (combinational ROM) or any later cycle.
  - While uncompleted, imem_addr stays stable and imem_req stays high unless a redirect or full condition arises. A dropped request is simply reissued.
  - On completion: push {pc, imem_instr} into the FIFO; pc <= pc+4 at the next edge.
- Decode handshake:
  - if_valid = !empty; if_instr/if_pc show the FIFO head.
  - Pop when if_valid && dec_ready.
  - Push and pop in the same cycle is allowed; count unchanged.
  - Steady state with dec_ready=1 and single-cycle memory: one instruction per cycle.
- Full: imem_req=0. The next request issues the cycle after a pop frees an entry.
- Redirect (priority over everything):
  - FIFO flushed (count=0, head/tail reset); pc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - Any completion or pop in that same cycle is discarded.
  - if_valid=0 in the following cycle. The first request to the target issues the cycle after redirect.
  - Back-to-back redirects: the last one wins.
- Arithmetic: pc+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0000_0000). FIFO pointers wrap modulo DEPTH. Count is width clog2(DEPTH)+1.
- Ordering: instructions leave in strictly increasing-PC order between redirects. No duplicates, no skips.
- Reset mid-operation: FIFO contents and pending request are abandoned. After release, fetch restarts at RESET_PC.
- Assertions:
  - imem_addr[1:0]==0 always.
  - if_pc of consecutive pops differs by 4 unless a redirect occurred.
  - No push when full.

Test Plan:
- Reset release, combinational memory, dec_ready=1 -> imem_addr 0,4,8,...; if_valid rises 1 cycle after first req; if_pc 0,4,8 on consecutive cycles.
- dec_ready=0 for 5 cycles -> FIFO fills to 2 (pcs 0,4), imem_req=0 and imem_addr held at 8. After dec_ready=1: if_pc 0,4,8 in order, no loss.
- imem_valid delayed 3 cycles per request -> imem_addr stable while waiting; each PC delivered exactly once.
- redirect_valid with redirect_pc=0x103 while FIFO holds 2 entries -> next cycle if_valid=0; next request addr 0x100; next if_pc 0x100.
- pc preloaded via redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- rst_n dropped mid-stream with FIFO full -> if_valid=0 and imem_req=0 immediately; after release, first imem_addr=RESET_PC.
